// File: rtl/ram_be_mp.sv
// Multi-read-port synchronous RAM with byte-enabled writes, optional output
// register, read-during-write control and an optional clear-on-reset sequencer.
module ram_be_mp #(
  parameter int    DATA_W         = 32,
  parameter int    DEPTH          = 256,
  parameter int    ADDR_W         = $clog2(DEPTH),
  parameter int    NUM_RD         = 2,
  parameter int    OUT_REG        = 1,
  parameter int    WRITE_FIRST    = 1,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = ""
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_we;
  logic              wr_ok;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NUM_RD-1:0]        s1_valid_q, s1_valid_d;
  logic [NUM_RD*DATA_W-1:0] s1_data_q, s1_data_d;
  logic [ADDR_W-1:0]        rd_a;
  logic [DATA_W-1:0]        rd_w;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        clr_we     = 1'b1;
        ready_d    = 1'b0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST) begin
          state_d    = S_RUN;
          ready_d    = 1'b1;
          clr_addr_d = '0;
        end
      end
      default: ready_d = 1'b1;
    endcase
  end

  assign wr_ok = ready_q && wr_en && in_range(wr_addr);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr_q] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Write-first merges the enabled lanes of the in-flight write into the read.
  always_comb begin
    s1_valid_d = '0;
    s1_data_d  = s1_data_q;
    rd_a       = '0;
    rd_w       = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_a = rd_addr[p*ADDR_W +: ADDR_W];
      rd_w = '0;
      if (ready_q && rd_en[p]) begin
        s1_valid_d[p] = 1'b1;
        if (in_range(rd_a)) begin
          rd_w = mem[rd_a];
          if (WRITE_FIRST != 0 && wr_ok && wr_addr == rd_a) begin
            for (int b = 0; b < NB; b++) begin
              if (wr_be[b]) rd_w[8*b +: 8] = wr_data[8*b +: 8];
            end
          end
        end
        s1_data_d[p*DATA_W +: DATA_W] = rd_w;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      ready_q    <= 1'b0;
      clr_addr_q <= '0;
      s1_valid_q <= '0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      clr_addr_q <= clr_addr_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [NUM_RD-1:0]        s2_valid_q, s2_valid_d;
    logic [NUM_RD*DATA_W-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s2_data_q;
      for (int p = 0; p < NUM_RD; p++) begin
        if (s1_valid_q[p]) begin
          s2_data_d[p*DATA_W +: DATA_W] = s1_data_q[p*DATA_W +: DATA_W];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid_q <= '0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_noreg
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

  assign ready = ready_q;

endmodule
